// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin session arbiter sharing one UART transmitter.
// Optional idle-grant watchdog is built in when UART_ARB_TIMEOUT_EN is defined.
//
// Ports:
//   clk, rst_n     system clock, async active-low reset
//   cli_req        per-client session request (level, held per message)
//   cli_grant      one-hot session owner (or zero)
//   cli_tx_data    client k byte in bits [8k+7:8k]
//   cli_tx_start   per-client byte request
//   cli_tx_busy    per-client registered busy view
//   uart_tx_data   byte launched to the UART
//   uart_tx_start  single-cycle launch pulse
//   uart_tx_busy   UART busy
//   active_id      current or last owner index
//   arb_idle       high while no session is granted
//   timeout_pulse  one-cycle pulse when the watchdog revokes a grant
module uart_tx_arbiter #(
  parameter int NUM_CLIENTS    = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CLIENTS-1:0]   cli_req,
  output logic [NUM_CLIENTS-1:0]   cli_grant,
  input  logic [8*NUM_CLIENTS-1:0] cli_tx_data,
  input  logic [NUM_CLIENTS-1:0]   cli_tx_start,
  output logic [NUM_CLIENTS-1:0]   cli_tx_busy,
  output logic [7:0]               uart_tx_data,
  output logic                     uart_tx_start,
  input  logic                     uart_tx_busy,
  output logic [1:0]               active_id,
  output logic                     arb_idle,
  output logic                     timeout_pulse
);

  if (NUM_CLIENTS < 2 || NUM_CLIENTS > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_tx_arbiter: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_SEND,
    S_DRAIN
  } state_t;

  state_t state;
  logic [1:0] ptr;
  logic [1:0] nxt_ptr;

  logic [NUM_CLIENTS-1:0] elig;
  logic                   pick_vld;
  logic [1:0]             pick_id;
  logic [NUM_CLIENTS-1:0] pick_oh;

  logic       own_req;
  logic       own_start;
  logic [7:0] own_data;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]       wd_cnt;
  // Revoked clients stay out of arbitration until they drop their request.
  logic [NUM_CLIENTS-1:0] mask;

  assign elig = cli_req & ~mask;
`else
  assign elig = cli_req;
`endif

  // Circular search for the first eligible requester at or after ptr.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    pick_oh  = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (!pick_vld && elig[(int'(ptr) + i) % NUM_CLIENTS]) begin
        pick_vld = 1'b1;
        pick_id  = 2'((int'(ptr) + i) % NUM_CLIENTS);
        pick_oh[(int'(ptr) + i) % NUM_CLIENTS] = 1'b1;
      end
    end
  end

  // Owner view: only the granted client's signals reach the UART.
  always_comb begin
    own_data = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (cli_grant[i]) begin
        own_data = cli_tx_data[8*i +: 8];
      end
    end
  end

  assign own_req   = |(cli_req & cli_grant);
  assign own_start = |(cli_tx_start & cli_grant);

  assign nxt_ptr = (active_id == 2'(NUM_CLIENTS - 1))
                 ? 2'd0
                 : active_id + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ptr           <= '0;
      cli_grant     <= '0;
      cli_tx_busy   <= '1;
      uart_tx_data  <= '0;
      uart_tx_start <= 1'b0;
      active_id     <= '0;
      arb_idle      <= 1'b1;
      timeout_pulse <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      wd_cnt        <= '0;
      mask          <= '0;
`endif
    end else begin
      uart_tx_start <= 1'b0;
      timeout_pulse <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      mask          <= mask & cli_req;
`endif
      unique case (state)
        S_IDLE: begin
          if (pick_vld) begin
            cli_grant   <= pick_oh;
            active_id   <= pick_id;
            cli_tx_busy <= ~pick_oh;
            arb_idle    <= 1'b0;
            state       <= S_GRANT;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
          end
        end
        S_GRANT: begin
          if (!own_req) begin
            cli_grant   <= '0;
            cli_tx_busy <= '1;
            ptr         <= nxt_ptr;
            arb_idle    <= 1'b1;
            state       <= S_IDLE;
          end else if (own_start && !uart_tx_busy) begin
            uart_tx_data  <= own_data;
            uart_tx_start <= 1'b1;
            cli_tx_busy   <= '1;
            state         <= S_SEND;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt        <= '0;
          end else if (wd_cnt == WD_MAX) begin
            cli_grant     <= '0;
            cli_tx_busy   <= '1;
            ptr           <= nxt_ptr;
            arb_idle      <= 1'b1;
            state         <= S_IDLE;
            mask          <= (mask & cli_req) | cli_grant;
            timeout_pulse <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        S_SEND: begin
          if (uart_tx_busy) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!uart_tx_busy) begin
            cli_tx_busy <= ~cli_grant;
            state       <= S_GRANT;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed + randomized checks of uart_tx_arbiter.
// Includes a simple UART busy model and a round-robin reference.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  cli_req = '0;
  logic [3:0]  cli_grant;
  logic [31:0] cli_tx_data = '0;
  logic [3:0]  cli_tx_start = '0;
  logic [3:0]  cli_tx_busy;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_start;
  logic        uart_tx_busy = 1'b0;
  logic [1:0]  active_id;
  logic        arb_idle;
  logic        timeout_pulse;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;

  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];

  int u_pend = 0;
  int u_dly  = 0;
  int u_dur  = 0;

  uart_tx_arbiter #(
    .NUM_CLIENTS   (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cli_req      (cli_req),
    .cli_grant    (cli_grant),
    .cli_tx_data  (cli_tx_data),
    .cli_tx_start (cli_tx_start),
    .cli_tx_busy  (cli_tx_busy),
    .uart_tx_data (uart_tx_data),
    .uart_tx_start(uart_tx_start),
    .uart_tx_busy (uart_tx_busy),
    .active_id    (active_id),
    .arb_idle     (arb_idle),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  // UART: capture each launch, go busy after 0..2 cycles, stay 2..5 cycles.
  always @(posedge clk) begin
    #1;
    if (uart_tx_start === 1'b1) begin
      cap_q.push_back(uart_tx_data);
      u_pend = 1;
      u_dly  = $urandom_range(0, 2);
      u_dur  = $urandom_range(1, 4);
    end else if (u_pend != 0) begin
      if (u_dly == 0) begin
        uart_tx_busy = 1'b1;
        u_pend = 0;
      end else begin
        u_dly--;
      end
    end else if (uart_tx_busy) begin
      if (u_dur == 0) uart_tx_busy = 1'b0;
      else u_dur--;
    end
  end

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_free(input int k);
    int n = 0;
    while (cli_tx_busy[k] !== 1'b0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 80) else begin
      errors++;
      $error("FAIL wait_free%0d: busy still %b, expected 0", k, cli_tx_busy[k]);
    end
  endtask

  task automatic accept(input int k, input logic [7:0] b);
    int p0;
    wait_free(k);
    cli_tx_data[8*k +: 8] = b;
    cli_tx_start[k] = 1'b1;
    exp_q.push_back(b);
    p0 = cap_q.size();
    @(negedge clk);
    check("acc_start", 32'(uart_tx_start), 32'd1);
    check("acc_data", 32'(uart_tx_data), 32'(b));
    check("acc_busy", 32'(cli_tx_busy[k]), 32'd1);
    check("acc_cap", cap_q.size(), p0 + 1);
    cli_tx_start[k] = 1'b0;
  endtask

  task automatic send_byte(input int k, input logic [7:0] b);
    accept(k, b);
    @(negedge clk);
    check("one_pulse", 32'(uart_tx_start), 32'd0);
  endtask

  task automatic release_gap(input int k);
    wait_free(k);
    cli_req[k] = 1'b0;
    ptr_m = (k + 1) % 4;
    @(negedge clk);
    check("rel_grant", 32'(cli_grant), 32'd0);
    check("rel_idle", 32'(arb_idle), 32'd1);
    check("rel_busy", 32'(cli_tx_busy), 32'hF);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cli_req = '0;
    cli_tx_start = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
  endtask

  initial begin
    int w, j, nb, n, p0;
    logic [3:0] rq;
    logic seen;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(cli_grant), 32'd0);
    check("rst_busy", 32'(cli_tx_busy), 32'hF);
    check("rst_data", 32'(uart_tx_data), 32'd0);
    check("rst_start", 32'(uart_tx_start), 32'd0);
    check("rst_id", 32'(active_id), 32'd0);
    check("rst_idle", 32'(arb_idle), 32'd1);
    check("rst_tmo", 32'(timeout_pulse), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Client 0 message 0x31 0x0A
    cli_req[0] = 1'b1;
    @(negedge clk);
    check("t1_grant", 32'(cli_grant), 32'h1);
    check("t1_id", 32'(active_id), 32'd0);
    check("t1_idle", 32'(arb_idle), 32'd0);
    check("t1_busy", 32'(cli_tx_busy), 32'hE);
    send_byte(0, 8'h31);
    send_byte(0, 8'h0A);
    release_gap(0);

    // Clients 1 and 2 together from reset, then client 0
    do_reset();
    cli_req = 4'b0110;
    w = rr_pick(cli_req, ptr_m);
    @(negedge clk);
    check("t2_first", 32'(cli_grant), 32'(1) << w);
    check("t2_id", 32'(active_id), 32'(w));
    send_byte(w, 8'($urandom));
    release_gap(w);
    w = rr_pick(cli_req, ptr_m);
    @(negedge clk);
    check("t2_second", 32'(cli_grant), 32'(1) << w);
    cli_req[0] = 1'b1;
    send_byte(w, 8'($urandom));
    release_gap(w);
    @(negedge clk);
    check("t2_third", 32'(cli_grant), 32'h1);

    // Non-owner client 3 start ignored
    p0 = cap_q.size();
    cli_tx_data[31:24] = 8'h55;
    cli_tx_start[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_nostart", 32'(uart_tx_start), 32'd0);
      check("t3_busy3", 32'(cli_tx_busy[3]), 32'd1);
    end
    cli_tx_start[3] = 1'b0;
    check("t3_nocap", cap_q.size(), p0);

    // Owner drops request one cycle after accept
    p0 = cap_q.size();
    accept(0, 8'hA7);
    cli_req[0] = 1'b0;
    @(negedge clk);
    check("t4_hold", 32'(cli_grant), 32'h1);
    n = 0;
    while (cli_grant[0] === 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    ptr_m = 1;
    check("t4_drop", 32'(cli_grant), 32'd0);
    check("t4_busy", 32'(cli_tx_busy), 32'hF);
    repeat (3) @(negedge clk);
    check("t4_pulses", cap_q.size(), p0 + 1);

    // Randomized sessions against the round-robin reference
    for (int s = 0; s < 25; s++) begin
      rq = cli_req | 4'($urandom_range(0, 15));
      if (rq == 4'd0) rq = 4'd1 << $urandom_range(0, 3);
      cli_req = rq;
      w = rr_pick(rq, ptr_m);
      @(negedge clk);
      check("rnd_grant", 32'(cli_grant), 32'(1) << w);
      check("rnd_id", 32'(active_id), 32'(w));
      j = (w + $urandom_range(1, 3)) % 4;
      cli_tx_data[8*j +: 8] = 8'($urandom);
      cli_tx_start[j] = 1'b1;
      @(negedge clk);
      check("rnd_junk_busy", 32'(cli_tx_busy[j]), 32'd1);
      check("rnd_junk_start", 32'(uart_tx_start), 32'd0);
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        send_byte(w, 8'($urandom));
        check("rnd_junk_busy2", 32'(cli_tx_busy[j]), 32'd1);
      end
      cli_tx_start[j] = 1'b0;
      release_gap(w);
    end
    cli_req = '0;
    repeat (2) @(negedge clk);

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog revoke after 16 idle grant cycles, masked until req toggles
    do_reset();
    cli_req[1] = 1'b1;
    @(negedge clk);
    check("wd_grant", 32'(cli_grant), 32'h2);
    n = 1;
    while (cli_grant[1] === 1'b1 && n < 100) begin
      @(negedge clk);
      if (cli_grant[1] === 1'b1) n++;
    end
    check("wd_len", n, 16);
    check("wd_pulse", 32'(timeout_pulse), 32'd1);
    @(negedge clk);
    check("wd_pulse_end", 32'(timeout_pulse), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("wd_masked", 32'(cli_grant), 32'd0);
      @(negedge clk);
    end
    cli_req[1] = 1'b0;
    @(negedge clk);
    cli_req[1] = 1'b1;
    @(negedge clk);
    check("wd_regrant", 32'(cli_grant), 32'h2);
    release_gap(1);
`else
    // Without the watchdog a silent owner keeps its grant
    do_reset();
    cli_req[1] = 1'b1;
    @(negedge clk);
    check("hold_grant", 32'(cli_grant), 32'h2);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (timeout_pulse !== 1'b0) seen = 1'b1;
    end
    check("hold_still", 32'(cli_grant), 32'h2);
    check("hold_no_tmo", 32'(seen), 32'd0);
    release_gap(1);
`endif

    // Asynchronous reset while draining a byte
    cli_req = 4'b0001;
    @(negedge clk);
    check("rd_grant", 32'(cli_grant), 32'h1);
    accept(0, 8'h5A);
    n = 0;
    while (uart_tx_busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("rd_owned", 32'(cli_grant), 32'h1);
    check("rd_drain_busy", 32'(cli_tx_busy), 32'hF);
    #1 rst_n = 1'b0;
    cli_req = 4'b0101;
    #1;
    check("rd_grant0", 32'(cli_grant), 32'd0);
    check("rd_busy1", 32'(cli_tx_busy), 32'hF);
    check("rd_data0", 32'(uart_tx_data), 32'd0);
    check("rd_start0", 32'(uart_tx_start), 32'd0);
    check("rd_id0", 32'(active_id), 32'd0);
    check("rd_idle1", 32'(arb_idle), 32'd1);
    check("rd_tmo0", 32'(timeout_pulse), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    w = rr_pick(cli_req, ptr_m);
    @(negedge clk);
    check("rd_first", 32'(cli_grant), 32'(1) << w);
    cli_req = '0;
    repeat (10) @(negedge clk);

    // Byte stream scoreboard
    check("sb_count", cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      check("sb_byte", 32'(cap_q[i]), 32'(exp_q[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
